// File: rtl/dst_debounce_pkg.sv
// rtl/dst_debounce_pkg.sv - shared types and constants for dst_debounce
// Contents:
//   dst_state_e : debounce FSM state (STABLE, CHECK)
//   EVT_CNT_W   : width of the optional accepted-transition counter
package dst_debounce_pkg;

  localparam int unsigned EVT_CNT_W = 16;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } dst_state_e;

endpackage

// File: rtl/dst_debounce_evt_cnt.sv
// rtl/dst_debounce_evt_cnt.sv - saturating counter of accepted debounce transitions
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset, clears the count
//   clr_i  : synchronous clear, wins over inc_i
//   inc_i  : count one event this cycle
//   cnt_o  : current count, saturates at all-ones
module dst_debounce_evt_cnt
  import dst_debounce_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [EVT_CNT_W-1:0] cnt_o
);

  logic [EVT_CNT_W-1:0] cnt_q;
  logic [EVT_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {EVT_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + EVT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dst_debounce.sv
// rtl/dst_debounce.sv - debouncer for an already-synchronized level
// Optional feature macro: DST_DEBOUNCE_EVT_CNT_EN (adds dst_evt_clr / dst_evt_cnt)
// Ports:
//   dst_clk     : clock, rising edge
//   dst_rst     : synchronous active-high reset
//   dst_en      : sample enable; low freezes all state
//   dst_data    : synchronized input level
//   dst_level   : debounced level
//   dst_rise    : one-cycle pulse on accepted 0->1
//   dst_fall    : one-cycle pulse on accepted 1->0
//   dst_evt_clr : (macro only) clear the transition counter
//   dst_evt_cnt : (macro only) saturating count of accepted transitions
module dst_debounce
  import dst_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        RST_VAL       = 1'b0
) (
  input  logic                 dst_clk,
  input  logic                 dst_rst,
  input  logic                 dst_en,
  input  logic                 dst_data,
`ifdef DST_DEBOUNCE_EVT_CNT_EN
  input  logic                 dst_evt_clr,
  output logic [EVT_CNT_W-1:0] dst_evt_cnt,
`endif
  output logic                 dst_level,
  output logic                 dst_rise,
  output logic                 dst_fall
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  dst_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             level_q, level_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (dst_en) begin
      case (state_q)
        STABLE: begin
          if (dst_data != level_q) begin
            if (STABLE_CYCLES == 1) begin
              // A single differing sample is already enough: accept directly.
              level_d = dst_data;
              rise_d  = dst_data;
              fall_d  = ~dst_data;
            end else begin
              // This edge is the first differing sample.
              state_d = CHECK;
              count_d = CNT_W'(1);
            end
          end
        end
        CHECK: begin
          if (dst_data == level_q) begin
            state_d = STABLE;
            count_d = '0;
          end else if (count_q == CNT_LAST) begin
            // STABLE_CYCLES-th consecutive differing sample.
            level_d = ~level_q;
            rise_d  = ~level_q;
            fall_d  = level_q;
            state_d = STABLE;
            count_d = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = STABLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge dst_clk) begin
    if (dst_rst) begin
      state_q <= STABLE;
      count_q <= '0;
      level_q <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dst_level = level_q;
  assign dst_rise  = rise_q;
  assign dst_fall  = fall_q;

`ifdef DST_DEBOUNCE_EVT_CNT_EN
  dst_debounce_evt_cnt u_evt_cnt (
    .clk_i (dst_clk),
    .rst_i (dst_rst),
    .clr_i (dst_evt_clr),
    .inc_i (rise_q | fall_q),
    .cnt_o (dst_evt_cnt)
  );
`endif

endmodule

// File: tb/tb_dst_debounce.sv
// tb/tb_dst_debounce.sv - directed testbench for dst_debounce
module tb_dst_debounce;
  import dst_debounce_pkg::*;

  logic clk;
  logic rst,  en,  data;
  logic level, rise, fall;
  logic rst1, en1, data1;
  logic level1, rise1, fall1;
`ifdef DST_DEBOUNCE_EVT_CNT_EN
  logic                 clr, clr1;
  logic [EVT_CNT_W-1:0] evt, evt1;
`endif

  int tests;
  int fails;

  dst_debounce #(.STABLE_CYCLES(4), .RST_VAL(1'b0)) dut (
    .dst_clk     (clk),
    .dst_rst     (rst),
    .dst_en      (en),
    .dst_data    (data),
`ifdef DST_DEBOUNCE_EVT_CNT_EN
    .dst_evt_clr (clr),
    .dst_evt_cnt (evt),
`endif
    .dst_level   (level),
    .dst_rise    (rise),
    .dst_fall    (fall)
  );

  dst_debounce #(.STABLE_CYCLES(1), .RST_VAL(1'b0)) dut1 (
    .dst_clk     (clk),
    .dst_rst     (rst1),
    .dst_en      (en1),
    .dst_data    (data1),
`ifdef DST_DEBOUNCE_EVT_CNT_EN
    .dst_evt_clr (clr1),
    .dst_evt_cnt (evt1),
`endif
    .dst_level   (level1),
    .dst_rise    (rise1),
    .dst_fall    (fall1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_main();
    rst = 1'b1; en = 1'b1; data = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; data = 1'b1;
    step();
    tests++;
    if ({level, rise, fall} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs got lvl/rise/fall=%b%b%b want 000", level, rise, fall);
    end
    tests++;
    if (dut.state_q !== STABLE || dut.count_q !== '0) begin
      fails++;
      $display("FAIL reset_state got state=%0d count=%0d want 0/0", dut.state_q, dut.count_q);
    end
  endtask

  task automatic test_rise();
    reset_main();
    data = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      tests++;
      if (level !== 1'b0 || rise !== 1'b0) begin
        fails++;
        $display("FAIL rise_early edge%0d got lvl=%b rise=%b want 0 0", i, level, rise);
      end
    end
    step();
    tests++;
    if (level !== 1'b1 || rise !== 1'b1 || fall !== 1'b0) begin
      fails++;
      $display("FAIL rise_edge4 got lvl=%b rise=%b fall=%b want 1 1 0", level, rise, fall);
    end
    step();
    tests++;
    if (level !== 1'b1 || rise !== 1'b0) begin
      fails++;
      $display("FAIL rise_after got lvl=%b rise=%b want 1 0", level, rise);
    end
  endtask

  task automatic test_glitch();
    reset_main();
    data = 1'b1;
    repeat (3) step();
    data = 1'b0;
    step();
    tests++;
    if (level !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || dut.state_q !== STABLE) begin
      fails++;
      $display("FAIL glitch_abort got lvl=%b rise=%b fall=%b state=%0d want 0 0 0 0",
               level, rise, fall, dut.state_q);
    end
    // A fresh run must again need 4 samples after the abort.
    data = 1'b1;
    repeat (3) step();
    tests++;
    if (level !== 1'b0) begin
      fails++;
      $display("FAIL glitch_restart got lvl=%b want 0", level);
    end
    step();
    tests++;
    if (level !== 1'b1) begin
      fails++;
      $display("FAIL glitch_restart_accept got lvl=%b want 1", level);
    end
  endtask

  task automatic test_enable_freeze();
    reset_main();
    data = 1'b1;
    repeat (5) step();
    data = 1'b0;
    repeat (2) step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data = i[0];
      step();
      tests++;
      if (level !== 1'b1 || fall !== 1'b0 || rise !== 1'b0) begin
        fails++;
        $display("FAIL freeze cyc%0d got lvl=%b rise=%b fall=%b want 1 0 0", i, level, rise, fall);
      end
    end
    en = 1'b1; data = 1'b0;
    step();
    tests++;
    if (level !== 1'b1 || fall !== 1'b0) begin
      fails++;
      $display("FAIL resume_edge1 got lvl=%b fall=%b want 1 0", level, fall);
    end
    step();
    tests++;
    if (level !== 1'b0 || fall !== 1'b1 || rise !== 1'b0) begin
      fails++;
      $display("FAIL resume_edge2 got lvl=%b fall=%b rise=%b want 0 1 0", level, fall, rise);
    end
    step();
    tests++;
    if (fall !== 1'b0) begin
      fails++;
      $display("FAIL fall_width got fall=%b want 0", fall);
    end
  endtask

  task automatic test_reset_mid_check();
    reset_main();
    data = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    tests++;
    if (level !== 1'b0 || dut.count_q !== '0 || dut.state_q !== STABLE) begin
      fails++;
      $display("FAIL rst_mid_check got lvl=%b count=%0d state=%0d want 0 0 0",
               level, dut.count_q, dut.state_q);
    end
    rst = 1'b0;
    repeat (3) step();
    tests++;
    if (level !== 1'b0) begin
      fails++;
      $display("FAIL rst_fresh3 got lvl=%b want 0", level);
    end
    step();
    tests++;
    if (level !== 1'b1 || rise !== 1'b1) begin
      fails++;
      $display("FAIL rst_fresh4 got lvl=%b rise=%b want 1 1", level, rise);
    end
  endtask

  task automatic test_single_cycle();
    rst1 = 1'b1; en1 = 1'b1; data1 = 1'b0;
    step();
    rst1 = 1'b0;
    tests++;
    if ({level1, rise1, fall1} !== 3'b000) begin
      fails++;
      $display("FAIL sc1_reset got %b%b%b want 000", level1, rise1, fall1);
    end
    for (int i = 0; i < 8; i++) begin
      data1 = ~data1;
      step();
      tests++;
      if (level1 !== data1 || rise1 !== data1 || fall1 !== ~data1) begin
        fails++;
        $display("FAIL sc1_toggle cyc%0d got lvl=%b rise=%b fall=%b want %b %b %b",
                 i, level1, rise1, fall1, data1, data1, ~data1);
      end
    end
    step();
    tests++;
    if (rise1 !== 1'b0 || fall1 !== 1'b0) begin
      fails++;
      $display("FAIL sc1_hold got rise=%b fall=%b want 0 0", rise1, fall1);
    end
  endtask

`ifdef DST_DEBOUNCE_EVT_CNT_EN
  task automatic toggles(input int n);
    for (int i = 0; i < n; i++) begin
      data1 = ~data1;
      step();
    end
    step();
  endtask

  task automatic test_evt_cnt();
    rst1 = 1'b1; en1 = 1'b1; data1 = 1'b0; clr1 = 1'b0;
    step();
    rst1 = 1'b0;
    tests++;
    if (evt1 !== 16'h0000) begin
      fails++;
      $display("FAIL evt_reset got %h want 0000", evt1);
    end
    toggles(65534);
    tests++;
    if (evt1 !== 16'hFFFE) begin
      fails++;
      $display("FAIL evt_preload got %h want fffe", evt1);
    end
    toggles(2);
    tests++;
    if (evt1 !== 16'hFFFF) begin
      fails++;
      $display("FAIL evt_saturate got %h want ffff", evt1);
    end
    toggles(1);
    tests++;
    if (evt1 !== 16'hFFFF) begin
      fails++;
      $display("FAIL evt_hold got %h want ffff", evt1);
    end
    data1 = ~data1;
    step();
    clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    tests++;
    if (evt1 !== 16'h0000) begin
      fails++;
      $display("FAIL evt_clr_wins got %h want 0000", evt1);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; en = 1'b0; data = 1'b0;
    rst1 = 1'b1; en1 = 1'b0; data1 = 1'b0;
`ifdef DST_DEBOUNCE_EVT_CNT_EN
    clr = 1'b0; clr1 = 1'b0;
`endif
    test_reset();
    test_rise();
    test_glitch();
    test_enable_freeze();
    test_reset_mid_check();
    test_single_cycle();
`ifdef DST_DEBOUNCE_EVT_CNT_EN
    test_evt_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dst_debounce.md
DST_DEBOUNCE -- requirements
Module: dst_debounce

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16, consecutive differing samples required to accept a transition (legal range 1..65536).
REQ-002 SHALL have parameter RST_VAL, default 1'b0, value of dst_level after reset.
REQ-003 SHALL have one clock and a synchronous, active-high reset; there are no other clock or reset inputs.
REQ-004 SHALL have port dst_clk  input  1  destination-domain clock, rising-edge active.
REQ-005 SHALL have port dst_rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port dst_en  input  1  sample enable; low freezes all state.
REQ-007 SHALL have port dst_data  input  1  level already synchronized to dst_clk by the upstream dff_sync stage.
REQ-008 SHALL have port dst_level  output  1  debounced level.
REQ-009 SHALL have port dst_rise  output  1  one-cycle pulse on an accepted 0->1 transition.
REQ-010 SHALL have port dst_fall  output  1  one-cycle pulse on an accepted 1->0 transition.

Function
REQ-011 SHALL implement FSM states STABLE and CHECK, with the debounce counter width set to clog2(STABLE_CYCLES+1).
REQ-012 In STABLE, when dst_en=1 and dst_data!=dst_level, the block SHALL go to CHECK with count=1; otherwise it SHALL hold.
REQ-013 In CHECK, when dst_en=1 and dst_data==dst_level, the block SHALL return to STABLE with count=0; no pulse.
REQ-014 In CHECK, when dst_en=1 and dst_data!=dst_level with count<STABLE_CYCLES-1, count SHALL increment.
REQ-015 In CHECK, when dst_en=1 and dst_data!=dst_level with count==STABLE_CYCLES-1, the block SHALL invert dst_level at that edge, return to STABLE, and clear count.
REQ-016 dst_rise/dst_fall SHALL be registered, asserted in the same cycle dst_level changes, and held for exactly one cycle; they are never both high.
REQ-017 Latency: dst_level SHALL change at the edge sampling the STABLE_CYCLES-th consecutive differing dst_data value (dst_en high).
REQ-018 For STABLE_CYCLES=1, CHECK SHALL be bypassed and dst_level SHALL follow dst_data with one register delay.
REQ-019 When dst_en=0, state, count and dst_level SHALL hold, pulses SHALL be 0, and input changes SHALL be ignored (neither counted nor aborting).
REQ-020 Count SHALL never exceed STABLE_CYCLES-1; no wrap is reachable.

Reset
REQ-021 On dst_rst=1 at a clock edge: state=STABLE, count=0, dst_level=RST_VAL, dst_rise=0, dst_fall=0.
REQ-022 Reset SHALL take priority over dst_en and dst_data, including mid-CHECK (an in-progress check is discarded).
REQ-023 A dst_data value differing from RST_VAL after reset SHALL be debounced normally (full STABLE_CYCLES), not accepted immediately.

Configuration
REQ-024 With macro DST_DEBOUNCE_EVT_CNT_EN defined, the block SHALL add port dst_evt_clr  input  1 and port dst_evt_cnt  output  16, a count of accepted transitions.
REQ-025 With DST_DEBOUNCE_EVT_CNT_EN, dst_evt_cnt SHALL increment on each rise/fall pulse, saturate at 16'hFFFF, clear on reset or dst_evt_clr, and clear (clr wins) when clr and a pulse coincide.
REQ-026 Without DST_DEBOUNCE_EVT_CNT_EN, these ports and this logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package dst_debounce_pkg SHALL hold the FSM state enum typedef and constant EVT_CNT_W=16.
REQ-028 The saturating counter SHALL be sub-module dst_debounce_evt_cnt, instantiated only under DST_DEBOUNCE_EVT_CNT_EN.

Verification (STABLE_CYCLES=4, RST_VAL=0)
REQ-029 Reset, then dst_data=1 held -> dst_level=1 and dst_rise=1 at the 4th sampling edge; dst_rise low next cycle.
REQ-030 dst_data=1 for 3 cycles then 0 -> dst_level stays 0, no pulse, state back to STABLE.
REQ-031 dst_level=1, dst_data=0 for 2 cycles, dst_en=0 for 5 cycles, then dst_en=1 for 2 cycles -> dst_fall at the 2nd enabled edge.
REQ-032 dst_rst asserted after 3 differing samples -> dst_level=0 and count=0; re-release needs 4 fresh samples.
REQ-033 STABLE_CYCLES=1: dst_data toggles every cycle -> dst_level equals dst_data delayed 1 cycle, with a pulse every cycle.
REQ-034 With DST_DEBOUNCE_EVT_CNT_EN: preload 16'hFFFE, two accepted transitions -> 16'hFFFF held; clr coincident with a pulse -> 0.
